seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
- Reader for the multiplexed seven-segment bus (seg/an) that the stopwatch drives.
- Samples the active-low cathode and anode lines, waits for each anode dwell to settle, and decodes the glyph back to a BCD digit and blank flag.
- Publishes one coherent four-digit frame at a time, with error and stale flags.
- Used as an on-board loopback/self-check monitor and as a synthesizable checker in benches.

Parameters:
- SETTLE_CYCLES, 16, consecutive clk cycles the registered anode must be stable before the segments are sampled; legal range 1..255.
- TIMEOUT_CYCLES, 1000000, clk cycles without a sample before stale asserts.

Ports:
- clk  in  1  100 MHz master clock.
- rst  in  1  asynchronous, active-high reset.
- seg  in  7  active-low cathodes; seg[0]=a ... seg[6]=g.
- an  in  4  active-low anodes; an[3] maps to digit3 (minutes tens) ... an[0] maps to digit0 (seconds ones).
- clr_err  in  1  synchronous clear of the sticky error flags.
- digit3, digit2, digit1, digit0  out  4 each  last published digit values.
- blank  out  4  bit i set when digit i was blank in the published frame.
- frame_done  out  1  one-cycle pulse when a new frame is published.
- pattern_err  out  1  sticky; an unrecognised glyph was sampled.
- mux_err  out  1  sticky; more than one anode was low at a sample point.
- stale  out  1  no sample taken for TIMEOUT_CYCLES.

Behaviour:
- Reset (async, active-high) values:
  - Outputs: all digits 0, blank=4'b1111, frame_done=0, pattern_err=0, mux_err=0, stale=0.
  - Internal: seen=0, shadow cleared, settle counter 0, timeout counter 0.
- Input stage:
  - seg and an are registered once (seg_r, an_r).
  - All decisions use the registered values, giving 1 cycle of input latency.
- State machine:
  - WAIT: an_r is 4'b1111, or an_r changed this cycle. Settle counter is 0. Go to SETTLE when an_r is not all-high and equals its previous value.
  - SETTLE: the counter increments each cycle an_r is unchanged. Any change of an_r returns to WAIT and clears the counter. When the count reaches SETTLE_CYCLES-1, go to SAMPLE.
  - SAMPLE: lasts exactly one cycle.
    - One-hot-low an_r: decode seg_r into shadow[idx] and set seen[idx].
    - Multiple lows: set mux_err; nothing is written.
    - Then go to HOLD.
  - HOLD: no further sampling during this dwell. Go to WAIT when an_r changes.
- Decode (active-low gfedcba):
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
  - 0x7F gives blank=1, value 0.
  - Any other pattern gives value 0, blank=0, and sets pattern_err. That digit still counts as seen.
- Publish:
  - When seen==4'b1111 at a cycle edge, the next cycle copies shadow to digit0..3 and blank, and pulses frame_done.
  - In that same cycle seen clears.
  - If a SAMPLE coincides with the publish cycle, seen becomes only that new bit and the shadow keeps the new sample.
  - Latency: 1 cycle from the SAMPLE of the last digit to frame_done.
- Outputs are stable between frame_done pulses. Repeated samples of the same digit before the frame completes overwrite its shadow entry.
- Stale and timeout:
  - The timeout counter saturates at TIMEOUT_CYCLES and resets on every SAMPLE.
  - stale=1 while the counter is saturated.
  - stale clears on the cycle after the next SAMPLE.
- Error clearing:
  - clr_err clears pattern_err and mux_err.
  - If clr_err and a new error occur in the same cycle, the error wins.
- Reset mid-dwell or mid-frame abandons partial frames; outputs return to their reset values immediately.

Optional Feature:
- Macro: SEG_HEX_DECODE_EN.
- When defined: A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E decode to 4'hA..4'hF without error.
- When undefined: those patterns are treated as unrecognised (value 0, pattern_err set).

Decomposition:
- Shared package seg_pkg:
  - glyph constants SEG_0..SEG_9, SEG_BLANK, SEG_A..SEG_F;
  - state encoding (WAIT, SETTLE, SAMPLE, HOLD);
  - anode-index width.
- One sub-module, seg_glyph_decode: combinational 7-bit to {valid, blank, value[3:0]}. It contains the SEG_HEX_DECODE_EN conditional.

Test Plan:
- Normal frame: drive a 4-digit scan of "12:34" (an 0111/1011/1101/1110 with 0x79/0x24/0x30/0x19), dwell 2 ms each, SETTLE_CYCLES=16.
  - Required: one frame_done; digit3..0 = 1,2,3,4; blank=0000; no errors.
- Blink: same scan with the minute digits driven 0x7F.
  - Required: blank=1100; digit3=0 and digit2=0; digit1=3 and digit0=4.
- Ghosting: toggle an every 10 cycles (below the settle time).
  - Required: no SAMPLE, no frame_done; stale asserts after TIMEOUT_CYCLES (set to 500 in the bench).
- Bad glyph and overlap: drive seg=0x55 on digit1, then an=0011 for 40 cycles.
  - Required: pattern_err=1 and mux_err=1; both stay set until clr_err; then both 0.
- Hex: drive 0x08 on digit0.
  - With SEG_HEX_DECODE_EN: digit0=4'hA, pattern_err=0.
  - Without it: digit0=0, pattern_err=1.
- Reset: assert rst mid-SETTLE after 3 of 4 digits are seen.
  - Required: outputs are at reset values asynchronously; the next full scan produces exactly one frame_done.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared glyph constants, FSM encoding and widths for the seven-segment scan reader
package seg_pkg;

    localparam int IDX_W = 2;

    // Active-low gfedcba cathode patterns
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/seg_glyph_decode.sv
// rtl/seg_glyph_decode.sv - combinational glyph to {valid, blank, value} decode
// Hex glyphs A..F are accepted only when SEG_HEX_DECODE_EN is defined.
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic       blank,
    output logic [3:0] value
);

    always_comb begin
        valid = 1'b1;
        blank = 1'b0;
        value = 4'h0;
        case (seg)
            SEG_0:     value = 4'h0;
            SEG_1:     value = 4'h1;
            SEG_2:     value = 4'h2;
            SEG_3:     value = 4'h3;
            SEG_4:     value = 4'h4;
            SEG_5:     value = 4'h5;
            SEG_6:     value = 4'h6;
            SEG_7:     value = 4'h7;
            SEG_8:     value = 4'h8;
            SEG_9:     value = 4'h9;
            SEG_BLANK: blank = 1'b1;
`ifdef SEG_HEX_DECODE_EN
            SEG_A:     value = 4'hA;
            SEG_B:     value = 4'hB;
            SEG_C:     value = 4'hC;
            SEG_D:     value = 4'hD;
            SEG_E:     value = 4'hE;
            SEG_F:     value = 4'hF;
`endif
            default:   valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - samples a multiplexed seven-segment bus and publishes coherent 4-digit frames
// Hex digit decode is enabled by SEG_HEX_DECODE_EN (see seg_glyph_decode).
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg,
    input  logic [3:0] an,
    input  logic       clr_err,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic [3:0] blank,
    output logic       frame_done,
    output logic       pattern_err,
    output logic       mux_err,
    output logic       stale
);

    localparam int         TMO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [6:0]       seg_r_q;
    logic [3:0]       an_r_q, an_prev_q;
    logic [7:0]       settle_cnt_q, settle_cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [3:0]       seen_q, seen_d;
    logic [3:0][3:0]  shadow_val_q, shadow_val_d;
    logic [3:0]       shadow_blank_q, shadow_blank_d;
    logic [3:0][3:0]  digit_q, digit_d;
    logic [3:0]       blank_q, blank_d;
    logic             frame_done_q, frame_done_d;
    logic             pattern_err_q, pattern_err_d;
    logic             mux_err_q, mux_err_d;

    logic             an_changed;
    logic             sample;
    logic [3:0]       an_low;
    logic             one_hot;
    logic [IDX_W-1:0] idx;
    logic             publish;
    logic             dec_valid, dec_blank;
    logic [3:0]       dec_value;

    seg_glyph_decode u_glyph (
        .seg   (seg_r_q),
        .valid (dec_valid),
        .blank (dec_blank),
        .value (dec_value)
    );

    assign an_changed = (an_r_q != an_prev_q);
    assign sample     = (state_q == ST_SAMPLE);
    assign an_low     = ~an_r_q;
    assign one_hot    = (an_low != 4'h0) && ((an_low & (an_low - 4'd1)) == 4'h0);

    always_comb begin
        case (an_r_q)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = 8'd0;
        case (state_q)
            ST_WAIT: begin
                if (an_r_q != 4'hF && !an_changed) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (an_changed)                      state_d = ST_WAIT;
                else if (settle_cnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
                else                                  settle_cnt_d = settle_cnt_q + 8'd1;
            end
            ST_SAMPLE: state_d = ST_HOLD;
            ST_HOLD: begin
                if (an_changed) state_d = ST_WAIT;
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // A full seen mask is consumed the cycle after it forms; a sample landing then starts the next frame.
    always_comb begin
        seen_d         = (seen_q == 4'hF) ? 4'h0 : seen_q;
        shadow_val_d   = shadow_val_q;
        shadow_blank_d = shadow_blank_q;
        pattern_err_d  = clr_err ? 1'b0 : pattern_err_q;
        mux_err_d      = clr_err ? 1'b0 : mux_err_q;
        if (sample) begin
            if (one_hot) begin
                shadow_val_d[idx]   = dec_value;
                shadow_blank_d[idx] = dec_blank;
                seen_d[idx]         = 1'b1;
                if (!dec_valid) pattern_err_d = 1'b1;
            end else begin
                mux_err_d = 1'b1;
            end
        end
        publish      = (seen_d == 4'hF);
        frame_done_d = publish;
        digit_d      = publish ? shadow_val_d   : digit_q;
        blank_d      = publish ? shadow_blank_d : blank_q;
        if (sample)                tmo_d = '0;
        else if (tmo_q == TMO_MAX) tmo_d = tmo_q;
        else                       tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_WAIT;
            seg_r_q        <= 7'h7F;
            an_r_q         <= 4'hF;
            an_prev_q      <= 4'hF;
            settle_cnt_q   <= 8'd0;
            tmo_q          <= '0;
            seen_q         <= 4'h0;
            shadow_val_q   <= '0;
            shadow_blank_q <= 4'h0;
            digit_q        <= '0;
            blank_q        <= 4'hF;
            frame_done_q   <= 1'b0;
            pattern_err_q  <= 1'b0;
            mux_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            seg_r_q        <= seg;
            an_r_q         <= an;
            an_prev_q      <= an_r_q;
            settle_cnt_q   <= settle_cnt_d;
            tmo_q          <= tmo_d;
            seen_q         <= seen_d;
            shadow_val_q   <= shadow_val_d;
            shadow_blank_q <= shadow_blank_d;
            digit_q        <= digit_d;
            blank_q        <= blank_d;
            frame_done_q   <= frame_done_d;
            pattern_err_q  <= pattern_err_d;
            mux_err_q      <= mux_err_d;
        end
    end

    assign digit3      = digit_q[3];
    assign digit2      = digit_q[2];
    assign digit1      = digit_q[1];
    assign digit0      = digit_q[0];
    assign blank       = blank_q;
    assign frame_done  = frame_done_q;
    assign pattern_err = pattern_err_q;
    assign mux_err     = mux_err_q;
    assign stale       = (tmo_q == TMO_MAX);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - scoreboard bench for seg_scan_decoder (honours SEG_HEX_DECODE_EN)
module tb_seg_scan_decoder;

    localparam int DWELL = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg;
    logic [3:0] an;
    logic       clr_err;
    logic [3:0] digit3, digit2, digit1, digit0, blank;
    logic       frame_done, pattern_err, mux_err, stale;

    int total  = 0;
    int bad    = 0;
    int frames = 0;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  blank;
    } frame_t;

    frame_t exp_q[$];

    always #5 clk = ~clk;

    seg_scan_decoder #(
        .SETTLE_CYCLES  (16),
        .TIMEOUT_CYCLES (500)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .an          (an),
        .clr_err     (clr_err),
        .digit3      (digit3),
        .digit2      (digit2),
        .digit1      (digit1),
        .digit0      (digit0),
        .blank       (blank),
        .frame_done  (frame_done),
        .pattern_err (pattern_err),
        .mux_err     (mux_err),
        .stale       (stale)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {err, blank, value}
    function automatic logic [5:0] ref_glyph(input logic [6:0] s);
        case (s)
            7'h40: return 6'h00;
            7'h79: return 6'h01;
            7'h24: return 6'h02;
            7'h30: return 6'h03;
            7'h19: return 6'h04;
            7'h12: return 6'h05;
            7'h02: return 6'h06;
            7'h78: return 6'h07;
            7'h00: return 6'h08;
            7'h10: return 6'h09;
            7'h7F: return 6'h10;
`ifdef SEG_HEX_DECODE_EN
            7'h08: return 6'h0A;
            7'h03: return 6'h0B;
            7'h46: return 6'h0C;
            7'h21: return 6'h0D;
            7'h06: return 6'h0E;
            7'h0E: return 6'h0F;
`endif
            default: return 6'h20;
        endcase
    endfunction

    function automatic frame_t ref_frame(input logic [6:0] s3, s2, s1, s0);
        logic [5:0] g3, g2, g1, g0;
        frame_t f;
        g3 = ref_glyph(s3);
        g2 = ref_glyph(s2);
        g1 = ref_glyph(s1);
        g0 = ref_glyph(s0);
        f.digits = {g3[3:0], g2[3:0], g1[3:0], g0[3:0]};
        f.blank  = {g3[4], g2[4], g1[4], g0[4]};
        return f;
    endfunction

    always @(negedge clk) begin
        if (!rst && frame_done) begin
            frame_t e;
            frames++;
            check("frame_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("frame_digits", {digit3, digit2, digit1, digit0}, e.digits);
                check("frame_blank", blank, e.blank);
            end
        end
    end

    task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_scan(input logic [6:0] s3, s2, s1, s0);
        int f0;
        f0 = frames;
        exp_q.push_back(ref_frame(s3, s2, s1, s0));
        dwell(4'b0111, s3, DWELL);
        dwell(4'b1011, s2, DWELL);
        dwell(4'b1101, s1, DWELL);
        dwell(4'b1110, s0, DWELL);
        check("scan_queue_drained", 32'(exp_q.size()), 32'd0);
        check("scan_one_frame", 32'(frames - f0), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digits"}, {digit3, digit2, digit1, digit0}, 32'h0);
        check({tag, "_blank"}, blank, 32'hF);
        check({tag, "_frame_done"}, frame_done, 32'd0);
        check({tag, "_pattern_err"}, pattern_err, 32'd0);
        check({tag, "_mux_err"}, mux_err, 32'd0);
        check({tag, "_stale"}, stale, 32'd0);
    endtask

    initial begin
        int f0;
        logic [5:0] g;
        rst     = 1'b1;
        seg     = 7'h7F;
        an      = 4'hF;
        clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // 12:34
        drive_scan(7'h79, 7'h24, 7'h30, 7'h19);
        check("normal_pattern_err", pattern_err, 32'd0);
        check("normal_mux_err", mux_err, 32'd0);

        // blinking minutes
        drive_scan(7'h7F, 7'h7F, 7'h30, 7'h19);
        check("blink_stale_before", stale, 32'd0);

        // ghosting: anode flips faster than the settle window
        f0 = frames;
        for (int i = 0; i < 60; i++) dwell((i % 2 == 0) ? 4'b1101 : 4'b1110, 7'h24, 10);
        check("ghost_no_frame", 32'(frames - f0), 32'd0);
        check("ghost_stale", stale, 32'd1);

        // bad glyph on digit1, then overlapping anodes
        drive_scan(7'h40, 7'h79, 7'h55, 7'h12);
        check("bad_stale_cleared", stale, 32'd0);
        check("bad_pattern_err", pattern_err, 32'd1);
        check("bad_mux_err_clear", mux_err, 32'd0);
        dwell(4'b0011, 7'h30, DWELL);
        check("overlap_mux_err", mux_err, 32'd1);
        check("overlap_pattern_err", pattern_err, 32'd1);
        repeat (20) @(posedge clk);
        #1;
        check("sticky_mux_err", mux_err, 32'd1);
        check("sticky_pattern_err", pattern_err, 32'd1);
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        check("clr_mux_err", mux_err, 32'd0);
        check("clr_pattern_err", pattern_err, 32'd0);

        // hex glyph on digit0
        drive_scan(7'h40, 7'h79, 7'h7F, 7'h08);
        g = ref_glyph(7'h08);
        check("hex_pattern_err", pattern_err, 32'(g[5]));
        check("hex_digit0", digit0, 32'(g[3:0]));

        // reset while digit0 is settling, three digits already seen
        dwell(4'b0111, 7'h10, DWELL);
        dwell(4'b1011, 7'h00, DWELL);
        dwell(4'b1101, 7'h78, DWELL);
        an  = 4'b1110;
        seg = 7'h02;
        repeat (8) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        dwell(4'hF, 7'h7F, 5);
        drive_scan(7'h12, 7'h02, 7'h78, 7'h00);
        check("post_reset_errs", {pattern_err, mux_err}, 32'd0);

        repeat (5) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
